// File: rtl/phase_timeout_pkg.sv
// Shared state encoding and default sizing for the phase/timeout sequencer.
package phase_timeout_pkg;

    localparam int N_PHASES_DEF = 4;
    localparam int CNT_W_DEF    = 4;
    localparam int PH_W_DEF     = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/phase_timeout_ctrl.sv
// Steps through N_PHASES phases, each lasting a programmable number of timer
// expiries, and owns the timer's clear so the timer only runs inside a phase.
module phase_timeout_ctrl
    import phase_timeout_pkg::*;
#(
    parameter int N_PHASES = N_PHASES_DEF,
    parameter int PH_W     = PH_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      tmo,
    input  logic [N_PHASES*CNT_W-1:0] len_phase,
    output logic                      timer_clr,
    output logic [PH_W-1:0]           phase,
    output logic                      busy,
    output logic                      phase_go,
    output logic                      done
);

    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(N_PHASES - 1);

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic              timer_clr_q, timer_clr_d;
    logic              busy_q, busy_d;
    logic              phase_go_q, phase_go_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  len_arr [N_PHASES];
    logic [CNT_W-1:0]  len_cur;

    generate
        for (genvar gi = 0; gi < N_PHASES; gi++) begin : g_len
            assign len_arr[gi] = len_phase[gi*CNT_W +: CNT_W];
        end
    endgenerate

    assign len_cur = len_arr[phase_q];

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        remaining_d = remaining_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARM;
                    phase_d = '0;
                end
            end
            ARM: begin
                remaining_d = len_cur;
                if (len_cur == '0) begin
                    // Zero-length phase: skip it without ever releasing the timer.
                    if (phase_q == LAST_PHASE) begin
                        state_d = FINISH;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                        state_d = ARM;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tmo && (remaining_q != '0)) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        if (phase_q == LAST_PHASE) begin
                            state_d = FINISH;
                        end else begin
                            phase_d = phase_q + PH_W'(1);
                            state_d = ARM;
                        end
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d     = IDLE;
            phase_d     = '0;
            remaining_d = '0;
        end

        // Outputs are derived from the next state so they register alongside it.
        timer_clr_d = (state_d != RUN);
        busy_d      = (state_d == ARM) || (state_d == RUN);
        phase_go_d  = (state_d == ARM);
        done_d      = (state_d == FINISH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            remaining_q <= '0;
            timer_clr_q <= 1'b1;
            busy_q      <= 1'b0;
            phase_go_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            remaining_q <= remaining_d;
            timer_clr_q <= timer_clr_d;
            busy_q      <= busy_d;
            phase_go_q  <= phase_go_d;
            done_q      <= done_d;
        end
    end

    assign timer_clr = timer_clr_q;
    assign phase     = phase_q;
    assign busy      = busy_q;
    assign phase_go  = phase_go_q;
    assign done      = done_q;

endmodule

// File: tb/tb_phase_timeout_ctrl.sv
// Self-checking bench: vector table, timer-driven sequences, async reset and a
// randomized run against a behavioural sequence model.
module tb_phase_timeout_ctrl;

    localparam int N     = 4;
    localparam int CW    = 4;
    localparam int PW    = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            start, abort, tmo_drv, use_timer;
    logic            tmo;
    logic [N*CW-1:0] len_phase;
    logic            timer_clr, busy, phase_go, done;
    logic [PW-1:0]   phase;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    phase_timeout_ctrl #(.N_PHASES(N), .PH_W(PW), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .tmo       (tmo),
        .len_phase (len_phase),
        .timer_clr (timer_clr),
        .phase     (phase),
        .busy      (busy),
        .phase_go  (phase_go),
        .done      (done)
    );

    // Stand-in for the 5-second timer: pulses once every 5 cycles while released.
    int   tmr_cnt;
    logic tmr_pulse;
    always_ff @(posedge clk or posedge timer_clr) begin
        if (timer_clr) begin
            tmr_cnt   <= 0;
            tmr_pulse <= 1'b0;
        end else if (tmr_cnt == 4) begin
            tmr_cnt   <= 0;
            tmr_pulse <= 1'b1;
        end else begin
            tmr_cnt   <= tmr_cnt + 1;
            tmr_pulse <= 1'b0;
        end
    end

    assign tmo = use_timer ? tmr_pulse : tmo_drv;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    typedef struct {
        logic            start;
        logic            abort;
        logic            tmo;
        logic [N*CW-1:0] len;
        logic            clr;
        int              ph;
        logic            busy;
        logic            go;
        logic            done;
    } vec_t;

    vec_t vecs[15];

    // Behavioural model: sequence described by flags and a countdown.
    bit m_in_seq, m_entering, m_finishing;
    int m_ph, m_left;

    function automatic int len_of(input logic [N*CW-1:0] v, input int ph);
        return int'((v >> (ph * CW)) & 16'hF);
    endfunction

    task automatic model_advance();
        if (m_ph == N - 1) begin
            m_in_seq    = 0;
            m_finishing = 1;
        end else begin
            m_ph       = m_ph + 1;
            m_entering = 1;
        end
    endtask

    task automatic model_step(input bit s, input bit a, input bit t, input logic [N*CW-1:0] lv);
        if (a) begin
            m_in_seq = 0; m_entering = 0; m_finishing = 0; m_ph = 0; m_left = 0;
        end else if (m_finishing) begin
            m_finishing = 0;
        end else if (m_entering) begin
            m_entering = 0;
            m_left     = len_of(lv, m_ph);
            if (m_left == 0) model_advance();
        end else if (m_in_seq) begin
            if (t) begin
                m_left = m_left - 1;
                if (m_left == 0) model_advance();
            end
        end else if (s) begin
            m_in_seq = 1; m_entering = 1; m_ph = 0;
        end
    endtask

    initial begin
        int n, go_cnt, tmo_cnt, done_n, dcount;
        bit done_seen;

        reset = 1'b1; start = 0; abort = 0; tmo_drv = 0; use_timer = 0;
        len_phase = '0;
        repeat (3) step();
        check("reset_timer_clr", timer_clr, 1);
        check("reset_busy", busy, 0);
        check("reset_phase", phase, 0);
        check("reset_phase_go", phase_go, 0);
        check("reset_done", done, 0);
        reset = 1'b0;
        step();

        // len = {ph0=2, ph1=0, ph2=0, ph3=1}
        vecs[0]  = '{1, 0, 0, 16'h1002, 1, 0, 1, 1, 0};
        vecs[1]  = '{0, 0, 1, 16'h1002, 0, 0, 1, 0, 0};
        vecs[2]  = '{0, 0, 1, 16'h1002, 0, 0, 1, 0, 0};
        vecs[3]  = '{0, 0, 0, 16'h1002, 0, 0, 1, 0, 0};
        vecs[4]  = '{0, 0, 1, 16'h1002, 1, 1, 1, 1, 0};
        vecs[5]  = '{0, 0, 1, 16'h1002, 1, 2, 1, 1, 0};
        vecs[6]  = '{0, 0, 0, 16'h1002, 1, 3, 1, 1, 0};
        vecs[7]  = '{0, 0, 0, 16'h1002, 0, 3, 1, 0, 0};
        vecs[8]  = '{0, 0, 1, 16'h1002, 1, 3, 0, 0, 1};
        vecs[9]  = '{0, 0, 0, 16'h1002, 1, 3, 0, 0, 0};
        vecs[10] = '{0, 0, 1, 16'h1002, 1, 3, 0, 0, 0};
        vecs[11] = '{1, 1, 0, 16'h1002, 1, 0, 0, 0, 0};
        vecs[12] = '{1, 0, 0, 16'h1002, 1, 0, 1, 1, 0};
        vecs[13] = '{0, 0, 0, 16'h1002, 0, 0, 1, 0, 0};
        vecs[14] = '{0, 1, 1, 16'h1002, 1, 0, 0, 0, 0};

        for (int i = 0; i < 15; i++) begin
            start = vecs[i].start; abort = vecs[i].abort;
            tmo_drv = vecs[i].tmo; len_phase = vecs[i].len;
            step();
            $display("vec %0d: clr=%0d ph=%0d busy=%0d go=%0d done=%0d", i,
                     timer_clr, phase, busy, phase_go, done);
            check($sformatf("vec%0d_timer_clr", i), timer_clr, vecs[i].clr);
            check($sformatf("vec%0d_phase", i), phase, vecs[i].ph);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("vec%0d_phase_go", i), phase_go, vecs[i].go);
            check($sformatf("vec%0d_done", i), done, vecs[i].done);
        end
        start = 0; abort = 0; tmo_drv = 0;
        step();

        // Nominal run with the timer attached: len = {1,2,1,3}.
        use_timer = 1; len_phase = 16'h3121;
        start = 1; step(); start = 0;
        check("nom_arm_go", phase_go, 1);
        check("nom_arm_phase", phase, 0);
        n = 0; go_cnt = 1; tmo_cnt = 0; done_seen = 0; done_n = -1;
        while (n < 200 && !done_seen) begin
            if (tmo && busy && !timer_clr) tmo_cnt++;
            step();
            n++;
            if (phase_go) begin
                check("nom_phase_order", phase, go_cnt);
                go_cnt++;
            end
            if (done) begin
                done_seen = 1;
                done_n = n;
            end
        end
        $display("nominal: done after %0d cycles, %0d phase_go, %0d tmo", done_n, go_cnt, tmo_cnt);
        check("nom_done_latency", done_n, 43);
        check("nom_phase_go_count", go_cnt, 4);
        check("nom_tmo_consumed", tmo_cnt, 7);
        step();
        check("nom_done_width", done, 0);
        check("nom_idle_busy", busy, 0);
        check("nom_idle_clr", timer_clr, 1);

        // Start held high, len = {1,1,1,1}: back-to-back sequences.
        len_phase = 16'h1111; start = 1;
        n = 0;
        while (n < 300 && !done) begin step(); n++; end
        check("held_first_done_seen", done, 1);
        step();
        check("held_gap_busy", busy, 0);
        check("held_gap_go", phase_go, 0);
        check("held_gap_done", done, 0);
        step();
        check("held_rearm_go", phase_go, 1);
        check("held_rearm_phase", phase, 0);
        n = 2; dcount = 0;
        while (n < 300 && !done) begin step(); n++; end
        $display("held start: done interval %0d cycles", n);
        check("held_done_interval", n, 30);
        start = 0;
        repeat (3) step();
        check("held_stop_idle", busy, 0);
        use_timer = 0;

        // Async reset while RUN with two expiries left.
        len_phase = 16'h0003;
        start = 1; step(); start = 0;
        step();
        tmo_drv = 1; step(); tmo_drv = 0;
        check("ar_run_clr", timer_clr, 0);
        check("ar_run_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("ar_async_clr", timer_clr, 1);
        check("ar_async_busy", busy, 0);
        check("ar_async_phase", phase, 0);
        step(); reset = 1'b0;
        step();
        start = 1; step(); start = 0;
        step();
        for (int k = 0; k < 2; k++) begin
            tmo_drv = 1; step(); tmo_drv = 0; step();
        end
        check("ar_full_count_clr", timer_clr, 0);
        check("ar_full_count_phase", phase, 0);
        tmo_drv = 1; step(); tmo_drv = 0;
        check("ar_third_tmo_go", phase_go, 1);
        check("ar_third_tmo_phase", phase, 1);
        repeat (6) step();
        check("ar_drain_idle", busy, 0);

        // Randomized run against the model.
        reset = 1'b1; step(); reset = 1'b0;
        m_in_seq = 0; m_entering = 0; m_finishing = 0; m_ph = 0; m_left = 0;
        dcount = 0;
        for (int c = 0; c < 3000; c++) begin
            start   = ($urandom_range(0, 2) == 0);
            abort   = ($urandom_range(0, 39) == 0);
            tmo_drv = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 7) == 0) begin
                for (int p = 0; p < N; p++)
                    len_phase[p*CW +: CW] = ($urandom_range(0, 15) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            end
            model_step(start, abort, tmo_drv, len_phase);
            step();
            check("rnd_timer_clr", timer_clr, (m_in_seq && !m_entering) ? 0 : 1);
            check("rnd_busy", busy, m_in_seq);
            check("rnd_phase_go", phase_go, m_entering);
            check("rnd_done", done, m_finishing);
            check("rnd_phase", phase, m_ph);
            if (m_finishing) dcount++;
        end
        $display("random: %0d sequences completed", dcount);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_timeout_ctrl.md
Name: phase_timeout_ctrl

Overview:
Phase sequencer that consumes the one-cycle expiry pulse of the 5-second timer block and drives that timer's clear input. It steps through N_PHASES phases, each lasting a programmable number of timer expiries. It then reports completion. It sits between the top-level control FSM and the timer, so the timer only ever runs while a phase is active.

Parameters:
N_PHASES, 4, number of phases in one sequence (>=1)
PH_W, 2, width of phase index, ceil(log2(N_PHASES)), min 1
CNT_W, 4, width of per-phase expiry count

Ports:
clk  input  1  system clock
reset  input  1  reset; asynchronous, active-high
start  input  1  level; sampled only in IDLE, begins sequence at phase 0
abort  input  1  level; returns to IDLE from any state, no done
tmo  input  1  one-cycle expiry pulse from the 5-second timer
len_phase  input  N_PHASES*CNT_W  expiry count per phase; phase i in bits [i*CNT_W +: CNT_W]; sampled at phase entry
timer_clr  output  1  drives the timer's reset; 1 holds the timer cleared
phase  output  PH_W  current phase index
busy  output  1  1 in ARM/RUN
phase_go  output  1  one-cycle pulse on entry to each phase (ARM)
done  output  1  one-cycle pulse after the last phase completes

Behaviour:
- All outputs registered. State changes happen on posedge clk.
- Reset (async): state=IDLE, phase=0, remaining=0, timer_clr=1, busy=0, phase_go=0, done=0.
- States: IDLE, ARM, RUN, FINISH.
- IDLE: timer_clr=1, busy=0. If start=1 and abort=0, then next state is ARM with phase=0.
- ARM: lasts exactly one cycle. timer_clr=1, busy=1, phase_go=1.
  - remaining loads len_phase[phase].
  - If the loaded value is 0, the phase is skipped: advance as in the RUN rule below, with no timer run.
  - Otherwise, next state is RUN.
- RUN: timer_clr=0, busy=1.
  - On tmo=1, remaining decrements.
  - If remaining==1 and tmo=1, the phase is complete:
    - if phase==N_PHASES-1, next state is FINISH;
    - else phase increments and next state is ARM. This re-clears the timer, so each phase starts from a full 5-count.
- FINISH: lasts one cycle. done=1, busy=0, timer_clr=1. Next state is IDLE. phase holds its last value until the next start.
- Latency: start sampled at edge k gives ARM (busy=1, phase_go=1) after edge k, and RUN (timer_clr=0) after edge k+1. The last tmo of the last phase at edge m gives done=1 after edge m, and IDLE after edge m+1.
- Boundary conditions:
  - abort has priority over everything, including a simultaneous tmo or start. Any state goes to IDLE on the next edge, phase=0, timer_clr=1, no done.
  - tmo in IDLE, ARM or FINISH is ignored. A single tmo never counts twice.
  - start while busy is ignored. start held high through FINISH restarts the sequence (IDLE then ARM) with no extra cycle beyond IDLE.
  - All phases with len=0: ARM steps once per phase, then FINISH. The timer is never released.
  - Async reset during RUN: outputs return to their reset values immediately, and timer_clr=1 asynchronously.
  - remaining is CNT_W bits. The maximum count is 2^CNT_W-1, and it never wraps.

Decomposition:
- Package phase_timeout_pkg holds the state enum (IDLE=2'd0, ARM=2'd1, RUN=2'd2, FINISH=2'd3) and the default N_PHASES, CNT_W and PH_W.
- No sub-module is required. Bench instances pair this block with the existing 5-second timer (timer_clr drives its reset, its pulse drives tmo).

Test Plan:
- Nominal run: N_PHASES=4, len={1,2,1,3}, start pulse. Expect phase to step 0,1,2,3; phase_go 4 times; exactly 7 tmo pulses consumed; done=1 once. With the real timer attached, done arrives 7*5 + 4*2 = 43 cycles after ARM entry, ±1 for FINISH.
- Zero-length phase: len={2,0,0,1}. Expect phase 1 and 2 to each hold for exactly one ARM cycle with timer_clr=1, no tmo consumed; total 3 tmo pulses, then done.
- Abort mid-RUN: abort=1 in phase 2 on the same cycle as tmo. Next cycle: IDLE, phase=0, timer_clr=1, busy=0, done never asserted.
- Spurious tmo: drive tmo=1 in IDLE and during ARM. remaining is unchanged; sequence timing identical to the nominal run.
- Async reset in RUN with remaining=2. timer_clr=1 and busy=0 before the next clk edge; a later start begins at phase 0 with a full count.
- Start held high continuously with len={1,1,1,1}. Expect back-to-back sequences separated by FINISH then IDLE (2 cycles), done pulsing once per sequence.
